exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the pipelined core: consumes the decode-to-execute register outputs, applies operand forwarding, performs the ALU operation, evaluates the instruction condition against the architectural NZCV flags register, and captures gated results into the execute-to-memory pipeline register. It owns the NZCV flags register. It sits between the decode/execute pipe and the memory stage.

## Interface
Parameters:
- none; datapath fixed at 32 bits, register address 4 bits.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears flags and EX/MEM register.
- RD1E, RD2E  in  32  register operands from the decode/execute pipe.
- ExtImmE  in  32  extended immediate.
- WA3E  in  4  destination register.
- PCSrcE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, FlagWriteE  in  1  control bits from the decode/execute pipe.
- ALUControlE  in  3  ALU operation.
- CondE  in  4  ARM condition field.
- ForwardAE, ForwardBE  in  2  forwarding selects from the hazard unit.
- ResultW  in  32  writeback-stage result for forwarding.
- StallM  in  1  hold the EX/MEM register and flags.
- FlushM  in  1  kill the EX instruction; insert a bubble.
- ALUResultM, WriteDataM  out  32  registered ALU result and store data.
- WA3M  out  4  registered destination.
- PCSrcM, RegWriteM, MemtoRegM, MemWriteM  out  1  registered, condition-gated control.
- FlagsOut  out  4  current NZCV register {N,Z,C,V}.
- CondExE  out  1  combinational condition-pass for the current EX instruction.

## Operation
- SrcA: the ForwardAE select chooses 00→RD1E, 10→ALUResultM, 01→ResultW, 11→RD1E. SrcB pre-mux uses ForwardBE/RD2E the same way. This value is WriteData. If ALUSrcE=1, SrcB=ExtImmE; otherwise SrcB=WriteData.
- ALUControlE: 000 ADD, 001 SUB (A−B), 010 AND, 011 ORR, 100 EOR, 101 MOV (B), 110 SUB (compare form; same result/flags as 001), 111 result 32'h0.
- Flags from the ALU: N=res[31], Z=(res==0).
  - ADD/SUB: C=carry out of the 33-bit sum. SUB computes A+~B+1, so C=1 means no borrow. V=signed overflow.
  - All other ops: C and V are preserved from the flags register.
- Condition pass (CondExE) uses FlagsOut:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - 1110 and 1111 both evaluate to 1.
- Gated control: PCSrc, RegWrite, MemWrite and the flag update are each ANDed with CondExE. MemtoReg is not gated.
- Flags register update: new NZCV is loaded iff FlagWriteE & CondExE & !StallM & !FlushM & !reset.
- EX/MEM register update, in priority order:
  1. reset: all outputs 0.
  2. FlushM: PCSrcM, RegWriteM, MemtoRegM and MemWriteM become 0. Data fields are don't-care and are implemented as 0.
  3. StallM: all fields hold.
  4. Otherwise: capture ALU result, WriteData, WA3E and gated control.

## Timing
- Reset values: ALUResultM=0, WriteDataM=0, WA3M=0, all control outputs 0, FlagsOut=4'b0000.
- Latency: one cycle from EX inputs to the M outputs.
- Flags written at edge t are visible to the condition check of the instruction in EX during cycle t+1. An instruction's condition never sees its own flag update.
- CondExE is purely combinational from CondE and FlagsOut.
- ALUResultM used as a forward source is the registered value, i.e. the previous instruction's result.
- Simultaneous FlushM and StallM: flush wins.
- Reset asserted mid-stall or mid-flush: reset wins on that edge.

## Configuration
- EXE_FORWARD_EN defined: the forwarding muxes are implemented as described above.
- EXE_FORWARD_EN undefined: ForwardAE, ForwardBE and ResultW remain as ports but are ignored. SrcA=RD1E and the SrcB pre-mux=RD2E. The hazard unit must then stall for every dependency.

## Test plan
- Overflow: reset; ADD with RD1E=32'h7FFFFFFF, RD2E=1, FlagWriteE=1, CondE=1110 → next cycle ALUResultM=32'h80000000, FlagsOut=1001 (N,V set).
- Borrow: SUB with 5−5 → ALUResultM=0, FlagsOut=0110 (Z,C). Then ORR 0|0 with FlagWriteE=1 → FlagsOut=0110 (Z set; C,V preserved).
- Conditional skip: FlagsOut Z=0; EQ-conditioned ADD with RegWriteE=1, MemWriteE=1 → RegWriteM=0, MemWriteM=0, flags unchanged. Then the same instruction with NE → RegWriteM=1.
- Stall/flush: StallM=1 for 2 cycles → all M outputs and FlagsOut hold. FlushM=1 and StallM=1 together with RegWriteE=1, FlagWriteE=1 → RegWriteM=0 and flags unchanged.
- Forwarding (macro on): ALUResultM=32'd10, ResultW=32'd3, RD1E=0, ForwardAE=10, ForwardBE=01, ADD → ALUResultM=13, WriteDataM=3. With the macro off, the same stimulus and RD2E=0 → ALUResultM=0.
- Reset mid-stall: StallM=1 with non-zero state, then reset=1 for one edge → all outputs 0, FlagsOut=0000.

Source files
------------

// File: rtl/exe_stage.sv
// exe_stage: execute stage of the pipelined core.
// Operand forwarding, ALU, NZCV flags register, ARM condition evaluation,
// and the EX/MEM pipeline register with stall/flush handling.
// Optional build macro: EXE_FORWARD_EN enables the forwarding muxes. When it
// is undefined, ForwardAE/ForwardBE/ResultW are ignored.
module exe_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] ExtImmE,
  input  logic [3:0]  WA3E,
  input  logic        PCSrcE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        ALUSrcE,
  input  logic        FlagWriteE,
  input  logic [2:0]  ALUControlE,
  input  logic [3:0]  CondE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  input  logic        StallM,
  input  logic        FlushM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [3:0]  WA3M,
  output logic        PCSrcM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic [3:0]  FlagsOut,
  output logic        CondExE
);

  function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] reg_val,
                                          input logic [31:0] mem_val, input logic [31:0] wb_val);
    case (sel)
      2'b10:   return mem_val;
      2'b01:   return wb_val;
      default: return reg_val;
    endcase
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: return z;
      4'b0001: return !z;
      4'b0010: return c;
      4'b0011: return !c;
      4'b0100: return n;
      4'b0101: return !n;
      4'b0110: return v;
      4'b0111: return !v;
      4'b1000: return c && !z;
      4'b1001: return !c || z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return !z && (n == v);
      4'b1101: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  logic signed [31:0] src_a_p0;
  logic signed [31:0] write_data_p0;
  logic signed [31:0] src_b_p0;
  logic signed [31:0] b_op_p0;
  logic signed [31:0] alu_res_p0;
  logic        [32:0] sum_p0;
  logic               sub_p0;
  logic               ovf_p0;
  logic               c_p0;
  logic               v_p0;
  logic        [3:0]  alu_flags_p0;

  logic [3:0]  flags_q, flags_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] write_data_q, write_data_d;
  logic [3:0]  wa3_q, wa3_d;
  logic        pcsrc_q, pcsrc_d;
  logic        reg_write_q, reg_write_d;
  logic        memto_reg_q, memto_reg_d;
  logic        mem_write_q, mem_write_d;

`ifdef EXE_FORWARD_EN
  // Operand selection with forwarding from the MEM register and writeback
  always_comb begin
    src_a_p0      = fwd_sel(ForwardAE, RD1E, alu_result_q, ResultW);
    write_data_p0 = fwd_sel(ForwardBE, RD2E, alu_result_q, ResultW);
    src_b_p0      = ALUSrcE ? ExtImmE : write_data_p0;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ForwardAE, ForwardBE, ResultW};

  // Operand selection straight from the register file; hazards are stalled
  always_comb begin
    src_a_p0      = RD1E;
    write_data_p0 = RD2E;
    src_b_p0      = ALUSrcE ? ExtImmE : write_data_p0;
  end
`endif

  // ALU: subtraction is A + ~B + 1 so carry-out means "no borrow"
  always_comb begin
    sub_p0     = (ALUControlE == 3'b001) || (ALUControlE == 3'b110);
    b_op_p0    = sub_p0 ? ~src_b_p0 : src_b_p0;
    sum_p0     = {1'b0, src_a_p0} + {1'b0, b_op_p0} + {32'b0, sub_p0};
    ovf_p0     = (src_a_p0[31] == b_op_p0[31]) && (sum_p0[31] != src_a_p0[31]);
    alu_res_p0 = '0;
    c_p0       = flags_q[1];
    v_p0       = flags_q[0];
    case (ALUControlE)
      3'b000, 3'b001, 3'b110: begin
        alu_res_p0 = sum_p0[31:0];
        c_p0       = sum_p0[32];
        v_p0       = ovf_p0;
      end
      3'b010:  alu_res_p0 = src_a_p0 & src_b_p0;
      3'b011:  alu_res_p0 = src_a_p0 | src_b_p0;
      3'b100:  alu_res_p0 = src_a_p0 ^ src_b_p0;
      3'b101:  alu_res_p0 = src_b_p0;
      default: alu_res_p0 = '0;
    endcase
    alu_flags_p0 = {alu_res_p0[31], (alu_res_p0 == 32'sd0), c_p0, v_p0};
  end

  assign CondExE = cond_pass(CondE, flags_q);

  // Flags update: only a condition-passing, non-stalled, non-flushed instruction
  always_comb begin
    flags_d = flags_q;
    if (FlagWriteE && CondExE && !StallM && !FlushM)
      flags_d = alu_flags_p0;
  end

  // EX/MEM next state: flush beats stall, stall holds, otherwise capture
  always_comb begin
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    wa3_d        = wa3_q;
    pcsrc_d      = pcsrc_q;
    reg_write_d  = reg_write_q;
    memto_reg_d  = memto_reg_q;
    mem_write_d  = mem_write_q;
    if (FlushM) begin
      alu_result_d = '0;
      write_data_d = '0;
      wa3_d        = '0;
      pcsrc_d      = 1'b0;
      reg_write_d  = 1'b0;
      memto_reg_d  = 1'b0;
      mem_write_d  = 1'b0;
    end else if (!StallM) begin
      alu_result_d = alu_res_p0;
      write_data_d = write_data_p0;
      wa3_d        = WA3E;
      pcsrc_d      = PCSrcE & CondExE;
      reg_write_d  = RegWriteE & CondExE;
      memto_reg_d  = MemtoRegE;
      mem_write_d  = MemWriteE & CondExE;
    end
  end

  // ---- EX / MEM stage boundary ----
  // State registers; reset overrides stall and flush
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q      <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      wa3_q        <= '0;
      pcsrc_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      memto_reg_q  <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      wa3_q        <= wa3_d;
      pcsrc_q      <= pcsrc_d;
      reg_write_q  <= reg_write_d;
      memto_reg_q  <= memto_reg_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign FlagsOut   = flags_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign WA3M       = wa3_q;
  assign PCSrcM     = pcsrc_q;
  assign RegWriteM  = reg_write_q;
  assign MemtoRegM  = memto_reg_q;
  assign MemWriteM  = mem_write_q;

endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: vector table with a scoreboard queue, plus
// hand-written stall, flush, forwarding and reset-during-stall sequences.
module tb_exe_stage;

  logic        clk;
  logic        reset;
  logic [31:0] RD1E, RD2E, ExtImmE, ResultW;
  logic [3:0]  WA3E, CondE;
  logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, FlagWriteE;
  logic [2:0]  ALUControlE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallM, FlushM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  WA3M, FlagsOut;
  logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM, CondExE;

  exe_stage dut (
    .clk(clk), .reset(reset),
    .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .WA3E(WA3E),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .FlagWriteE(FlagWriteE),
    .ALUControlE(ALUControlE), .CondE(CondE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .StallM(StallM), .FlushM(FlushM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .FlagsOut(FlagsOut), .CondExE(CondExE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl / ctrlm bit order: {PCSrc, RegWrite, MemtoReg, MemWrite}
  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm;
    logic        alusrc, fw;
    logic [3:0]  cond, ctrl, wa3;
    logic        cex;
    logic [31:0] alu, wd;
    logic [3:0]  ctrlm, flags;
  } vec_t;

  typedef struct packed {
    logic [31:0] alu, wd;
    logic [3:0]  wa3, ctrl, flags;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] imm, input logic alusrc, input logic fw,
                              input logic [3:0] cond, input logic [3:0] ctrl, input logic [3:0] wa3,
                              input logic cex, input logic [31:0] alu, input logic [31:0] wd,
                              input logic [3:0] ctrlm, input logic [3:0] flags);
    vec_t v;
    v = '{op, rd1, rd2, imm, alusrc, fw, cond, ctrl, wa3, cex, alu, wd, ctrlm, flags};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RD1E = v.rd1; RD2E = v.rd2; ExtImmE = v.imm; ALUSrcE = v.alusrc;
    FlagWriteE = v.fw; ALUControlE = v.op; CondE = v.cond; WA3E = v.wa3;
    {PCSrcE, RegWriteE, MemtoRegE, MemWriteE} = v.ctrl;
  endtask

  task automatic check_out(input exp_t e, input string tag);
    chk({tag, " ALUResultM"}, ALUResultM, e.alu);
    chk({tag, " WriteDataM"}, WriteDataM, e.wd);
    chk({tag, " WA3M"}, {28'd0, WA3M}, {28'd0, e.wa3});
    chk({tag, " ctrlM"}, {28'd0, PCSrcM, RegWriteM, MemtoRegM, MemWriteM}, {28'd0, e.ctrl});
    chk({tag, " FlagsOut"}, {28'd0, FlagsOut}, {28'd0, e.flags});
  endtask

  // One clock edge, then compare against the oldest scoreboard entry
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end else begin
      check_out(sb.pop_front(), tag);
    end
  endtask

  initial begin
    exp_t held;
    vec_t hv;
    reset = 1'b1; StallM = 1'b0; FlushM = 1'b0;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 32'h0000_0003;
    drive(mk(3'b000, 32'h1234, 32'h5678, 32'h9, 1'b0, 1'b1, 4'hE, 4'hF, 4'h7,
             1'b0, 32'h0, 32'h0, 4'h0, 4'h0));

    // op  rd1  rd2  imm  alusrc fw cond ctrl wa3 | cex alu wd ctrlM flags
    vt.push_back(mk(3'b000, 32'h7FFFFFFF, 32'h1, 32'h0, 0, 1, 4'hE, 4'b0100, 4'h3, 1, 32'h80000000, 32'h1, 4'b0100, 4'b1001));
    vt.push_back(mk(3'b001, 32'h5, 32'h5, 32'h0, 0, 1, 4'hE, 4'b0100, 4'h4, 1, 32'h0, 32'h5, 4'b0100, 4'b0110));
    vt.push_back(mk(3'b011, 32'h0, 32'h0, 32'h0, 0, 1, 4'hE, 4'b0100, 4'h5, 1, 32'h0, 32'h0, 4'b0100, 4'b0110));
    vt.push_back(mk(3'b000, 32'h1, 32'h1, 32'h0, 0, 1, 4'hE, 4'b0000, 4'h6, 1, 32'h2, 32'h1, 4'b0000, 4'b0000));
    vt.push_back(mk(3'b000, 32'h3, 32'h4, 32'h0, 0, 1, 4'h0, 4'b1111, 4'h7, 0, 32'h7, 32'h4, 4'b0010, 4'b0000));
    vt.push_back(mk(3'b000, 32'h3, 32'h4, 32'h0, 0, 1, 4'h1, 4'b1111, 4'h7, 1, 32'h7, 32'h4, 4'b1111, 4'b0000));
    vt.push_back(mk(3'b001, 32'h3, 32'h5, 32'h0, 0, 1, 4'hE, 4'b0101, 4'h8, 1, 32'hFFFFFFFE, 32'h5, 4'b0101, 4'b1000));
    vt.push_back(mk(3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 0, 1, 4'hB, 4'b0100, 4'h9, 1, 32'hF000F000, 32'hFF00FF00, 4'b0100, 4'b1000));
    vt.push_back(mk(3'b100, 32'hFF, 32'hF, 32'h0, 0, 1, 4'hA, 4'b0100, 4'hA, 0, 32'hF0, 32'hF, 4'b0000, 4'b1000));
    vt.push_back(mk(3'b101, 32'h0, 32'hAAAA, 32'h12345678, 1, 1, 4'h4, 4'b0100, 4'hB, 1, 32'h12345678, 32'hAAAA, 4'b0100, 4'b0000));
    vt.push_back(mk(3'b111, 32'h55, 32'h66, 32'h0, 0, 1, 4'h5, 4'b0100, 4'hC, 1, 32'h0, 32'h66, 4'b0100, 4'b0100));
    vt.push_back(mk(3'b110, 32'h80000000, 32'h1, 32'h0, 0, 1, 4'h9, 4'b0000, 4'hD, 1, 32'h7FFFFFFF, 32'h1, 4'b0000, 4'b0011));
    vt.push_back(mk(3'b000, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 1, 4'h8, 4'b0100, 4'hE, 1, 32'h0, 32'h1, 4'b0100, 4'b0110));
    vt.push_back(mk(3'b000, 32'h1, 32'h2, 32'h0, 0, 1, 4'hC, 4'b0100, 4'hF, 0, 32'h3, 32'h2, 4'b0000, 4'b0110));
    vt.push_back(mk(3'b001, 32'h2, 32'h1, 32'h0, 0, 0, 4'hD, 4'b0100, 4'h1, 1, 32'h1, 32'h1, 4'b0100, 4'b0110));
    vt.push_back(mk(3'b000, 32'h9, 32'h9, 32'h0, 0, 1, 4'h3, 4'b1000, 4'h2, 0, 32'h12, 32'h9, 4'b0000, 4'b0110));
    vt.push_back(mk(3'b000, 32'h0, 32'h0, 32'h0, 0, 1, 4'hF, 4'b1000, 4'h3, 1, 32'h0, 32'h0, 4'b1000, 4'b0100));
    vt.push_back(mk(3'b000, 32'h7FFFFFFF, 32'h0, 32'h7FFFFFFF, 1, 1, 4'h7, 4'b0010, 4'h4, 1, 32'hFFFFFFFE, 32'h0, 4'b0010, 4'b1001));
    vt.push_back(mk(3'b100, 32'h3, 32'h5, 32'h0, 0, 0, 4'h6, 4'b0100, 4'h5, 1, 32'h6, 32'h5, 4'b0100, 4'b1001));
    vt.push_back(mk(3'b101, 32'h0, 32'h2, 32'h0, 0, 1, 4'h2, 4'b0101, 4'h6, 0, 32'h2, 32'h2, 4'b0000, 4'b1001));
    vt.push_back(mk(3'b011, 32'h1, 32'h2, 32'h0, 0, 0, 4'hE, 4'b0111, 4'h5, 1, 32'h3, 32'h2, 4'b0111, 4'b1001));

    // Reset state and combinational condition with flags 0000
    repeat (2) @(posedge clk);
    #1;
    check_out('{alu: 32'h0, wd: 32'h0, wa3: 4'h0, ctrl: 4'h0, flags: 4'h0}, "reset");
    CondE = 4'h0; #1; chk("reset EQ cex", {31'd0, CondExE}, 32'd0);
    CondE = 4'h1; #1; chk("reset NE cex", {31'd0, CondExE}, 32'd1);
    reset = 1'b0;

    // Table vectors
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      #1;
      chk($sformatf("vec%0d CondExE", i), {31'd0, CondExE}, {31'd0, vt[i].cex});
      sb.push_back('{alu: vt[i].alu, wd: vt[i].wd, wa3: vt[i].wa3, ctrl: vt[i].ctrlm, flags: vt[i].flags});
      step($sformatf("vec%0d", i));
    end

    // Stall for two cycles: outputs and flags hold the last table result
    held = '{alu: 32'h3, wd: 32'h2, wa3: 4'h5, ctrl: 4'b0111, flags: 4'b1001};
    hv = mk(3'b000, 32'h1, 32'h1, 32'h0, 0, 1, 4'hE, 4'b1111, 4'h9, 1, 32'h0, 32'h0, 4'h0, 4'h0);
    drive(hv);
    StallM = 1'b1;
    sb.push_back(held); step("stall1");
    sb.push_back(held); step("stall2");

    // Flush together with stall: bubble inserted, flags untouched
    FlushM = 1'b1;
    sb.push_back('{alu: 32'h0, wd: 32'h0, wa3: 4'h0, ctrl: 4'h0, flags: 4'b1001});
    step("flush+stall");
    FlushM = 1'b0; StallM = 1'b0;

    // Forwarding: seed ALUResultM = 10
    drive(mk(3'b000, 32'h4, 32'h6, 32'h0, 0, 0, 4'hE, 4'b0100, 4'h1, 1, 32'h0, 32'h0, 4'h0, 4'h0));
    sb.push_back('{alu: 32'd10, wd: 32'd6, wa3: 4'h1, ctrl: 4'b0100, flags: 4'b1001});
    step("fwd seed");

    drive(mk(3'b000, 32'h0, 32'h0, 32'h0, 0, 0, 4'hE, 4'b0100, 4'h2, 1, 32'h0, 32'h0, 4'h0, 4'h0));
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'd3;
`ifdef EXE_FORWARD_EN
    sb.push_back('{alu: 32'd13, wd: 32'd3, wa3: 4'h2, ctrl: 4'b0100, flags: 4'b1001});
`else
    sb.push_back('{alu: 32'd0, wd: 32'd0, wa3: 4'h2, ctrl: 4'b0100, flags: 4'b1001});
`endif
    step("fwd A=M B=W");

    drive(mk(3'b000, 32'd100, 32'h0, 32'h0, 0, 0, 4'hE, 4'b0100, 4'h3, 1, 32'h0, 32'h0, 4'h0, 4'h0));
    ForwardAE = 2'b01; ForwardBE = 2'b10;
`ifdef EXE_FORWARD_EN
    sb.push_back('{alu: 32'd16, wd: 32'd13, wa3: 4'h3, ctrl: 4'b0100, flags: 4'b1001});
`else
    sb.push_back('{alu: 32'd100, wd: 32'd0, wa3: 4'h3, ctrl: 4'b0100, flags: 4'b1001});
`endif
    step("fwd A=W B=M");

    drive(mk(3'b000, 32'd7, 32'd8, 32'h0, 0, 0, 4'hE, 4'b0100, 4'h4, 1, 32'h0, 32'h0, 4'h0, 4'h0));
    ForwardAE = 2'b11; ForwardBE = 2'b11;
    sb.push_back('{alu: 32'd15, wd: 32'd8, wa3: 4'h4, ctrl: 4'b0100, flags: 4'b1001});
    step("fwd sel11");
    ForwardAE = 2'b00; ForwardBE = 2'b00;

    // Reset during a stall clears everything
    StallM = 1'b1; reset = 1'b1;
    sb.push_back('{alu: 32'h0, wd: 32'h0, wa3: 4'h0, ctrl: 4'h0, flags: 4'h0});
    step("reset mid-stall");
    CondE = 4'h5; #1; chk("post-reset PL cex", {31'd0, CondExE}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
